cursor_bombas: RTL and testbench
================================

Name: cursor_bombas

Overview:
- Upstream controller for the bomb-placement stage `colocarMostrar` in the Laboratorio 4 minesweeper board.
- Turns player push-buttons into the cursor coordinates `col`/`fila` and a bomb-place strobe `button_bomba`.
- Holds the authoritative 8x8 board register. It drives `seleccion_matriz` into `colocarMostrar` and latches `matriz_salida` back after each placement, closing the feedback loop.
- Counts placed bombs and flags when the configured total is reached.

Parameters:
- N_BOMBAS, 10, number of bombs to place before `placing_done`; range 1..64.
- DEBOUNCE_CYCLES, 500000, stable-low cycles required for a press (used only with the debounce feature).
- SETTLE_CYCLES, 2, cycles `button_bomba` stays high after its rising edge before the commit latch; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; clears the board and count, enables placement
- btn_up_n  in  1  active-low button, fila-1
- btn_down_n  in  1  active-low button, fila+1
- btn_left_n  in  1  active-low button, col-1
- btn_right_n  in  1  active-low button, col+1
- btn_place_n  in  1  active-low button, place bomb at the cursor
- matriz_salida  in  8x[7:0]  board returned by `colocarMostrar`
- col  out  3  cursor column
- fila  out  3  cursor row
- button_bomba  out  1  placement strobe to `colocarMostrar`, idle high
- seleccion_matriz  out  8x[7:0]  registered board; row index = fila, bit index = col
- bomb_count  out  7  bombs placed
- reject  out  1  one-cycle pulse: placement refused
- placing_done  out  1  high once bomb_count == N_BOMBAS

Behaviour:
- Reset, asynchronous, active-high. Outputs take these values:
  - col=0, fila=0
  - button_bomba=1
  - all seleccion_matriz rows = 8'h00
  - bomb_count=0, reject=0, placing_done=0
  - FSM in OFF
- Button inputs: each passes through a 2-flop synchroniser. A press is the falling edge of the synchronised signal, giving a one-cycle event.
- FSM states:
  - OFF: ignores all buttons.
  - start -> board cleared, count=0, done=0 -> IDLE.
  - start in any state behaves the same way and aborts any in-flight placement; button_bomba returns to 1.
- IDLE:
  - Move events update the cursor with modulo-8 wrap (7+1=0, 0-1=7).
  - Simultaneous up and down cancel; same for left and right. Orthogonal moves apply together.
  - A place event takes priority over moves in the same cycle; the moves are dropped.
  - Place on a cell where seleccion_matriz[fila][col]=1 -> reject pulse, stay in IDLE.
  - Place on a free cell -> STROBE_LO, with cursor values frozen.
- STROBE_LO: button_bomba=0 for exactly 1 cycle -> STROBE_HI.
- STROBE_HI:
  - button_bomba=1 for SETTLE_CYCLES cycles, so the downstream rising-edge capture and its combinational output settle.
  - Then -> COMMIT.
- COMMIT:
  - seleccion_matriz <= matriz_salida; bomb_count +1.
  - If the new count == N_BOMBAS -> DONE, else -> IDLE.
- DONE: placing_done=1; moves and places are ignored. A place event pulses reject.
- Button events in STROBE_LO, STROBE_HI or COMMIT are discarded, not queued.
- Latency: place event to button_bomba low = 1 cycle. Place event to board update = 2+SETTLE_CYCLES+1 cycles.
- bomb_count saturates at N_BOMBAS.

Optional Feature:
- Macro: CURSOR_BOMBAS_DEBOUNCE_EN.
- Defined: each synchronised button feeds a per-button counter. A press event fires only after DEBOUNCE_CYCLES consecutive low samples, once per press. Release requires the same number of consecutive high samples before the next press counts.
- Undefined: raw synchronised falling edges are used, suitable for simulation. The DEBOUNCE_CYCLES parameter is then unused.

Decomposition:
- Package `bombas_pkg` holds:
  - the FSM state enum (OFF, IDLE, STROBE_LO, STROBE_HI, COMMIT, DONE)
  - the board typedef `tablero_t` = logic [7:0] [7:0]
  - constant BOARD_DIM=8
- Sub-module `boton_evento`, instantiated 5 times: synchroniser, optional debounce and falling-edge detect, producing a one-cycle event output.

Test Plan:
- Reset then start; press right twice, down once -> col=2, fila=1; board all zero; button_bomba=1.
- Cursor at col=0, fila=0; press left, then up -> col=7, fila=7 (wrap-around).
- Place at col=1, fila=1 with `colocarMostrar` attached:
  - button_bomba low exactly 1 cycle.
  - After commit, seleccion_matriz[1]=8'b00000010 and bomb_count=1.
- Place again at col=1, fila=1 -> reject pulses 1 cycle; no button_bomba low; bomb_count stays 1.
- N_BOMBAS=3; place at (3,0), (0,5), (6,6):
  - placing_done=1 after the third commit.
  - A further place pulses reject.
  - start clears the board, count=0, done=0.
- Assert rst during STROBE_LO -> button_bomba=1 immediately (async); board zero; FSM in OFF.

Source files
------------

// File: rtl/bombas_pkg.sv
// Shared types for the minesweeper bomb-placement controller: FSM states and the 8x8 board.
package bombas_pkg;

  localparam int BOARD_DIM = 8;

  typedef logic [BOARD_DIM-1:0][BOARD_DIM-1:0] tablero_t;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    IDLE      = 3'd1,
    STROBE_LO = 3'd2,
    STROBE_HI = 3'd3,
    COMMIT    = 3'd4,
    DONE      = 3'd5
  } estado_t;

endpackage

// File: rtl/boton_evento.sv
// Active-low push-button to one-cycle press event: 2-flop synchroniser, optional debounce
// (CURSOR_BOMBAS_DEBOUNCE_EN), falling-edge detect.
module boton_evento #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic evento
);

  logic sync1;
  logic sync2;

  // Two-flop synchroniser; idle level of the button is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

`ifdef CURSOR_BOMBAS_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          estable;

  // The accepted level only flips after DEBOUNCE_CYCLES consecutive opposite samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      estable <= 1'b1;
      evento  <= 1'b0;
    end else begin
      evento <= 1'b0;
      if (sync2 == estable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt     <= '0;
        estable <= sync2;
        evento  <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
`else
  logic prev;

  // Raw falling edge of the synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= 1'b1;
      evento <= 1'b0;
    end else begin
      prev   <= sync2;
      evento <= prev & ~sync2;
    end
  end
`endif

endmodule

// File: rtl/cursor_bombas.sv
// Cursor/bomb-placement controller feeding colocarMostrar and owning the board register.
// Optional debounce of the buttons: define CURSOR_BOMBAS_DEBOUNCE_EN.
module cursor_bombas
  import bombas_pkg::*;
#(
  parameter int unsigned N_BOMBAS        = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  logic     btn_up_n,
  input  logic     btn_down_n,
  input  logic     btn_left_n,
  input  logic     btn_right_n,
  input  logic     btn_place_n,
  input  tablero_t matriz_salida,
  output logic [2:0] col,
  output logic [2:0] fila,
  output logic     button_bomba,
  output tablero_t seleccion_matriz,
  output logic [6:0] bomb_count,
  output logic     reject,
  output logic     placing_done
);

  localparam int unsigned SW      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [6:0]  N_TOTAL = 7'(N_BOMBAS);

  logic ev_up, ev_down, ev_left, ev_right, ev_place;

  boton_evento #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up    (.clk(clk), .rst(rst), .btn_n(btn_up_n),    .evento(ev_up));
  boton_evento #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down  (.clk(clk), .rst(rst), .btn_n(btn_down_n),  .evento(ev_down));
  boton_evento #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left  (.clk(clk), .rst(rst), .btn_n(btn_left_n),  .evento(ev_left));
  boton_evento #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (.clk(clk), .rst(rst), .btn_n(btn_right_n), .evento(ev_right));
  boton_evento #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_place (.clk(clk), .rst(rst), .btn_n(btn_place_n), .evento(ev_place));

  estado_t       estado;
  logic [SW-1:0] settle_cnt;

  // Placement FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado           <= OFF;
      settle_cnt       <= '0;
      col              <= 3'd0;
      fila             <= 3'd0;
      button_bomba     <= 1'b1;
      seleccion_matriz <= '0;
      bomb_count       <= 7'd0;
      reject           <= 1'b0;
      placing_done     <= 1'b0;
    end else if (start) begin
      estado           <= IDLE;
      settle_cnt       <= '0;
      button_bomba     <= 1'b1;
      seleccion_matriz <= '0;
      bomb_count       <= 7'd0;
      reject           <= 1'b0;
      placing_done     <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (estado)
        OFF: begin
          estado <= OFF;
        end
        IDLE: begin
          if (ev_place) begin
            if (seleccion_matriz[fila][col]) begin
              reject <= 1'b1;
            end else begin
              button_bomba <= 1'b0;
              estado       <= STROBE_LO;
            end
          end else begin
            // Opposite moves in the same cycle cancel; orthogonal ones both apply.
            if (ev_down && !ev_up) fila <= fila + 3'd1;
            else if (ev_up && !ev_down) fila <= fila - 3'd1;
            if (ev_right && !ev_left) col <= col + 3'd1;
            else if (ev_left && !ev_right) col <= col - 3'd1;
          end
        end
        STROBE_LO: begin
          button_bomba <= 1'b1;
          settle_cnt   <= '0;
          estado       <= STROBE_HI;
        end
        STROBE_HI: begin
          // Give colocarMostrar time to capture the rising edge and settle its output.
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            estado <= COMMIT;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        COMMIT: begin
          seleccion_matriz <= matriz_salida;
          if (bomb_count + 7'd1 >= N_TOTAL) begin
            bomb_count   <= N_TOTAL;
            placing_done <= 1'b1;
            estado       <= DONE;
          end else begin
            bomb_count <= bomb_count + 7'd1;
            estado     <= IDLE;
          end
        end
        DONE: begin
          placing_done <= 1'b1;
          if (ev_place) reject <= 1'b1;
        end
        default: begin
          estado <= OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_bombas.sv
// Directed bench for cursor_bombas with a behavioural colocarMostrar attached (N_BOMBAS=3).
module tb_cursor_bombas;
  import bombas_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     start = 1'b0;
  logic     btn_up_n = 1'b1, btn_down_n = 1'b1, btn_left_n = 1'b1, btn_right_n = 1'b1, btn_place_n = 1'b1;
  tablero_t matriz_salida;
  logic [2:0] col, fila;
  logic     button_bomba;
  tablero_t seleccion_matriz;
  logic [6:0] bomb_count;
  logic     reject, placing_done;

  int checks = 0;
  int failures = 0;
  int lo_cycles, rj_cycles;

  localparam logic [4:0] B_UP = 5'b00001, B_DOWN = 5'b00010, B_LEFT = 5'b00100,
                         B_RIGHT = 5'b01000, B_PLACE = 5'b10000;

  cursor_bombas #(.N_BOMBAS(3), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .btn_up_n(btn_up_n), .btn_down_n(btn_down_n), .btn_left_n(btn_left_n),
    .btn_right_n(btn_right_n), .btn_place_n(btn_place_n),
    .matriz_salida(matriz_salida),
    .col(col), .fila(fila), .button_bomba(button_bomba),
    .seleccion_matriz(seleccion_matriz), .bomb_count(bomb_count),
    .reject(reject), .placing_done(placing_done)
  );

  always #5 clk = ~clk;

  // colocarMostrar stand-in: on the strobe rising edge, mark the cursor cell.
  tablero_t mat = '0;
  always @(posedge button_bomba) begin
    mat = seleccion_matriz;
    mat[fila][col] = 1'b1;
  end
  assign matriz_salida = mat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    btn_up_n    = ~m[0];
    btn_down_n  = ~m[1];
    btn_left_n  = ~m[2];
    btn_right_n = ~m[3];
    btn_place_n = ~m[4];
  endtask

  // Hold the masked buttons for 4 cycles, release, watch strobe and reject for 20 cycles.
  task automatic press(input logic [4:0] m);
    lo_cycles = 0;
    rj_cycles = 0;
    drive(m);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) drive(5'b00000);
      if (button_bomba === 1'b0) lo_cycles++;
      if (reject === 1'b1) rj_cycles++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_col", 64'(col), 64'd0);
    check("rst_fila", 64'(fila), 64'd0);
    check("rst_bb", 64'(button_bomba), 64'd1);
    check("rst_board", seleccion_matriz, 64'd0);
    check("rst_count", 64'(bomb_count), 64'd0);
    check("rst_reject", 64'(reject), 64'd0);
    check("rst_done", 64'(placing_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    press(B_RIGHT);
    check("off_ignores_move", 64'(col), 64'd0);

    pulse_start();
    press(B_RIGHT);
    press(B_RIGHT);
    press(B_DOWN);
    check("move_col", 64'(col), 64'd2);
    check("move_fila", 64'(fila), 64'd1);
    check("move_board", seleccion_matriz, 64'd0);
    check("move_bb", 64'(button_bomba), 64'd1);

    press(B_LEFT);
    press(B_LEFT);
    press(B_UP);
    press(B_LEFT);
    press(B_UP);
    check("wrap_col", 64'(col), 64'd7);
    check("wrap_fila", 64'(fila), 64'd7);

    press(B_RIGHT | B_DOWN);
    check("diag_col", 64'(col), 64'd0);
    check("diag_fila", 64'(fila), 64'd0);
    press(B_UP | B_DOWN | B_RIGHT);
    check("cancel_fila", 64'(fila), 64'd0);
    check("cancel_orth_col", 64'(col), 64'd1);
    press(B_LEFT | B_RIGHT | B_DOWN);
    check("cancel_col", 64'(col), 64'd1);
    check("cancel_orth_fila", 64'(fila), 64'd1);

    press(B_PLACE);
    check("place_lo_cycles", 64'(lo_cycles), 64'd1);
    check("place_reject", 64'(rj_cycles), 64'd0);
    check("place_board", seleccion_matriz, 64'h0000_0000_0000_0200);
    check("place_count", 64'(bomb_count), 64'd1);
    check("place_done", 64'(placing_done), 64'd0);

    press(B_PLACE);
    check("dup_reject", 64'(rj_cycles), 64'd1);
    check("dup_lo_cycles", 64'(lo_cycles), 64'd0);
    check("dup_count", 64'(bomb_count), 64'd1);

    press(B_PLACE | B_RIGHT);
    check("prio_reject", 64'(rj_cycles), 64'd1);
    check("prio_col", 64'(col), 64'd1);

    pulse_start();
    check("start_board", seleccion_matriz, 64'd0);
    check("start_count", 64'(bomb_count), 64'd0);

    press(B_RIGHT);
    press(B_RIGHT);
    press(B_UP);
    check("pos_a", 64'({col, fila}), 64'({3'd3, 3'd0}));
    press(B_PLACE);
    press(B_LEFT);
    press(B_LEFT);
    press(B_LEFT);
    press(B_UP);
    press(B_UP);
    press(B_UP);
    check("pos_b", 64'({col, fila}), 64'({3'd0, 3'd5}));
    press(B_PLACE);
    check("count_two", 64'(bomb_count), 64'd2);
    check("done_early", 64'(placing_done), 64'd0);
    press(B_LEFT);
    press(B_LEFT);
    press(B_DOWN);
    press(B_PLACE);
    check("third_lo_cycles", 64'(lo_cycles), 64'd1);
    check("full_board", seleccion_matriz, 64'h0040_0100_0000_0008);
    check("full_count", 64'(bomb_count), 64'd3);
    check("full_done", 64'(placing_done), 64'd1);

    press(B_RIGHT);
    check("done_no_move", 64'(col), 64'd6);
    press(B_PLACE);
    check("done_reject", 64'(rj_cycles), 64'd1);
    check("done_no_strobe", 64'(lo_cycles), 64'd0);
    check("done_count_sat", 64'(bomb_count), 64'd3);

    pulse_start();
    check("restart_board", seleccion_matriz, 64'd0);
    check("restart_count", 64'(bomb_count), 64'd0);
    check("restart_done", 64'(placing_done), 64'd0);

    seen = 1'b0;
    drive(B_PLACE);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (button_bomba === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("strobe_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    #1;
    check("async_bb", 64'(button_bomba), 64'd1);
    check("async_board", seleccion_matriz, 64'd0);
    check("async_col", 64'(col), 64'd0);
    drive(5'b00000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press(B_RIGHT);
    check("async_off", 64'(col), 64'd0);
    press(B_PLACE);
    check("async_off_place", 64'(lo_cycles + rj_cycles), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
